// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared framebuffer geometry, RGB332 field positions, writer op codes and writer FSM states
package vga_fb_pkg;
  localparam int H_RES = 400;
  localparam int V_RES = 300;
  localparam int BUF_SIZE = H_RES * V_RES;
  localparam int ADDR_W = 19;
  localparam int RED_LSB = 0;
  localparam int RED_MSB = 2;
  localparam int GRN_LSB = 3;
  localparam int GRN_MSB = 5;
  localparam int BLU_LSB = 6;
  localparam int BLU_MSB = 7;
  localparam logic OP_PLOT = 1'b0;
  localparam logic OP_FILL = 1'b1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wr_state_t;
endpackage

// File: rtl/vga_fb_addr_gen.sv
// vga_fb_addr_gen: registered (x,y,buf) -> SRAM address; ld loads, inc steps, last flags final address of the loaded buffer
module vga_fb_addr_gen #(
  parameter int H_RES = vga_fb_pkg::H_RES,
  parameter int V_RES = vga_fb_pkg::V_RES,
  parameter int ADDR_W = vga_fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic              inc,
  input  logic              buf_sel,
  input  logic [8:0]        x,
  input  logic [8:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  import vga_fb_pkg::*;
  localparam logic [ADDR_W-1:0] BSZ = ADDR_W'(H_RES * V_RES);
  localparam logic [ADDR_W-1:0] END0 = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] END1 = ADDR_W'(2 * H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] HR = ADDR_W'(H_RES);
  logic [ADDR_W-1:0] lin;
  logic cur_buf;
  assign lin = ADDR_W'(y) * HR + ADDR_W'(x) + (buf_sel ? BSZ : '0);
  assign last = addr == (cur_buf ? END1 : END0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      cur_buf <= 1'b0;
    end else if (ld) begin
      addr <= lin;
      cur_buf <= buf_sel;
    end else if (inc) begin
      addr <= addr + 1'b1;
    end
endmodule

// File: rtl/vga_frame_writer.sv
// vga_frame_writer: plot/fill command writer into double-buffered RGB332 SRAM; cmd valid/ready in, SRAM strobes out during grant, front-buffer select to renderer
module vga_frame_writer #(
  parameter int H_RES = vga_fb_pkg::H_RES,
  parameter int V_RES = vga_fb_pkg::V_RES,
  parameter int ADDR_W = vga_fb_pkg::ADDR_W,
  parameter int WE_CYCLES = 2
) (
  input  logic              WRITER_CLK,
  input  logic              WRITER_RST_N,
  input  logic              WRITER_CMD_VALID,
  output logic              WRITER_CMD_READY,
  input  logic              WRITER_CMD_OP,
  input  logic [8:0]        WRITER_CMD_X,
  input  logic [8:0]        WRITER_CMD_Y,
  input  logic [7:0]        WRITER_CMD_COLOR,
  input  logic              WRITER_SWAP_REQ,
  input  logic              WRITER_FRAME_START,
  input  logic              WRITER_SRAM_GRANT,
  output logic [ADDR_W-1:0] WRITER_ADDR,
  output logic [7:0]        WRITER_DATA,
  output logic              WRITER_DATA_OE,
  output logic              WRITER_WE,
  output logic              WRITER_OE,
  output logic              WRITER_CE,
  output logic              WRITER_SEL_BUFF,
  output logic              WRITER_BUSY,
  output logic              WRITER_CLIP
);
  import vga_fb_pkg::*;
  localparam int CW = WE_CYCLES > 1 ? $clog2(WE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WE_CYCLES - 1);
  wr_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic ready, we, drive, sel_buff, busy, clip, pend, pend_d, fill;
  logic [7:0] data;
  logic accept, in_range, ld, more, done, swap_now, last;
  assign accept = WRITER_CMD_VALID & ready;
  assign in_range = WRITER_CMD_X < 9'(H_RES) && WRITER_CMD_Y < 9'(V_RES);
  assign ld = accept & (WRITER_CMD_OP == OP_FILL | in_range);
  assign more = fill & ~last;
  assign done = state == HOLD & ~more;
  // a swap never coincides with an accept, so an accepted command always targets the buffer it was addressed for
  assign swap_now = WRITER_FRAME_START & state == IDLE & (pend | WRITER_SWAP_REQ) & ~accept;
  assign pend_d = (pend | WRITER_SWAP_REQ) & ~swap_now;
  vga_fb_addr_gen #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_addr (
    .clk(WRITER_CLK),
    .rst_n(WRITER_RST_N),
    .ld(ld),
    .inc(state == HOLD & more),
    .buf_sel(~sel_buff),
    .x(WRITER_CMD_OP == OP_FILL ? 9'd0 : WRITER_CMD_X),
    .y(WRITER_CMD_OP == OP_FILL ? 9'd0 : WRITER_CMD_Y),
    .addr(WRITER_ADDR),
    .last(last)
  );
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      IDLE: state_d = ld ? SETUP : IDLE;
      SETUP: begin
        state_d = WRITER_SRAM_GRANT ? STROBE : SETUP;
        cnt_d = '0;
      end
      STROBE: begin
        state_d = cnt == CNT_LAST ? HOLD : STROBE;
        cnt_d = cnt + 1'b1;
      end
      default: state_d = more ? SETUP : IDLE;
    endcase
  end
  always_ff @(posedge WRITER_CLK or negedge WRITER_RST_N)
    if (!WRITER_RST_N) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  always_ff @(posedge WRITER_CLK or negedge WRITER_RST_N)
    if (!WRITER_RST_N) begin
      ready <= 1'b0;
      we <= 1'b1;
      drive <= 1'b0;
      sel_buff <= 1'b0;
      busy <= 1'b0;
      clip <= 1'b0;
      pend <= 1'b0;
      fill <= 1'b0;
      data <= '0;
    end else begin
      ready <= state_d == IDLE & ~pend_d & ~accept;
      we <= state_d != STROBE;
      busy <= state_d != IDLE | pend_d;
      clip <= accept & WRITER_CMD_OP == OP_PLOT & ~in_range;
      pend <= pend_d;
      drive <= ld | (drive & ~done);
      fill <= ld ? WRITER_CMD_OP == OP_FILL : fill;
      data <= ld ? WRITER_CMD_COLOR : data;
      sel_buff <= sel_buff ^ swap_now;
    end
  assign WRITER_CMD_READY = ready;
  assign WRITER_DATA = data;
  assign WRITER_DATA_OE = drive;
  assign WRITER_CE = ~drive;
  assign WRITER_WE = we;
  assign WRITER_OE = 1'b1;
  assign WRITER_SEL_BUFF = sel_buff;
  assign WRITER_BUSY = busy;
  assign WRITER_CLIP = clip;
endmodule

// File: doc/vga_frame_writer.md
Name: vga_frame_writer

Overview:
- Write-side counterpart to the VGA scan-out renderer, on the same external 8-bit SRAM holding two 400x300 RGB332 framebuffers.
- Accepts plot-pixel and fill-buffer commands over a valid/ready handshake, converts (x,y) to SRAM addresses, and generates SRAM write strobes only while the bus is granted (blanking).
- Owns the front/back buffer selection and drives the renderer's buffer-select input, so a buffer swap never tears a displayed frame.

Parameters:
- H_RES, 400, pixels per line in framebuffer
- V_RES, 300, lines per framebuffer
- ADDR_W, 19, SRAM address width
- WE_CYCLES, 2, clocks WE is held low per write (must be >= 1)

Ports:
- WRITER_CLK  in  1  system clock
- WRITER_RST_N  in  1  reset, asynchronous, active-low
- WRITER_CMD_VALID  in  1  command valid
- WRITER_CMD_READY  out  1  command accepted when VALID&READY at posedge
- WRITER_CMD_OP  in  1  0=plot pixel, 1=fill draw buffer
- WRITER_CMD_X  in  9  pixel column, 0..H_RES-1 (ignored for fill)
- WRITER_CMD_Y  in  9  pixel row, 0..V_RES-1 (ignored for fill)
- WRITER_CMD_COLOR  in  8  RGB332: [2:0] red, [5:3] green, [7:6] blue
- WRITER_SWAP_REQ  in  1  one-cycle pulse, request front/back swap
- WRITER_FRAME_START  in  1  one-cycle pulse at scan position (0,0)
- WRITER_SRAM_GRANT  in  1  SRAM bus free for writes (display blanking)
- WRITER_ADDR  out  ADDR_W  SRAM address
- WRITER_DATA  out  8  SRAM write data
- WRITER_DATA_OE  out  1  drive data bus (tristate enable)
- WRITER_WE  out  1  SRAM write enable, active-low
- WRITER_OE  out  1  SRAM output enable, active-low (held 1)
- WRITER_CE  out  1  SRAM chip enable, active-low
- WRITER_SEL_BUFF  out  1  front buffer index, to renderer
- WRITER_BUSY  out  1  command or pending swap in progress
- WRITER_CLIP  out  1  one-cycle pulse: plot dropped, out of range

Behaviour:
- Reset values (asynchronous): state IDLE; READY=0; WE=1; OE=1; CE=1; DATA_OE=0; ADDR=0; DATA=0; SEL_BUFF=0; BUSY=0; CLIP=0; swap_pending=0. Draw buffer is always ~SEL_BUFF, so buffer 1 after reset.
- READY is registered. It is 1 when state is IDLE, swap_pending=0 and not in reset. It drops in the cycle after acceptance.
- Address = H_RES*y + x + H_RES*V_RES*draw_buf, computed at ADDR_W bits. Maximum is 239999, so no overflow.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: on accepted plot with x<H_RES and y<V_RES, latch ADDR and DATA, set DATA_OE=1 and CE=0, go to SETUP. On accepted out-of-range plot, pulse CLIP for 1 cycle, write nothing, stay in IDLE. On accepted fill, ADDR = draw-buffer base, go to SETUP.
- SETUP: WE=1. Advance to STROBE only in a cycle where GRANT=1; otherwise wait indefinitely.
- STROBE: WE=0 for exactly WE_CYCLES clocks. It is atomic: GRANT falling mid-strobe does not abort it. The GRANT source must give at least WE_CYCLES+2 clocks of notice.
- HOLD: WE=1, ADDR and DATA unchanged for 1 clock. For a fill not yet at base+H_RES*V_RES-1, ADDR increments and the FSM returns to SETUP. Otherwise DATA_OE=0, CE=1, go to IDLE.
- Plot latency: accept at cycle 0, WE low in cycles 2..1+WE_CYCLES, READY back in cycle 3+WE_CYCLES with continuous grant.
- Fill takes (2+WE_CYCLES)*H_RES*V_RES clocks under continuous grant.
- Swap:
  - SWAP_REQ sets swap_pending at any time; further requests while pending are ignored.
  - Pending blocks new commands; an in-flight plot or fill completes into the old draw buffer.
  - SEL_BUFF toggles on the first FRAME_START where state is IDLE and swap_pending=1, which also clears pending. A FRAME_START during a fill is skipped until the next frame.
  - Simultaneous SWAP_REQ and FRAME_START in IDLE: swap takes effect on that same FRAME_START.
- BUSY = (state != IDLE) | swap_pending.

Decomposition:
- Package vga_fb_pkg holds:
  - H_RES, V_RES, BUF_SIZE=H_RES*V_RES, ADDR_W
  - RGB332 field positions, shared with the renderer
  - op encoding: OP_PLOT, OP_FILL
  - FSM state enum
- One sub-module, vga_fb_addr_gen: registered (x,y,buf) -> address with increment and last-address flag, used by both plot and fill.

Test Plan:
- Plot after reset, x=10, y=5, COLOR=0xA5, GRANT=1: ADDR=122010, DATA=0xA5, WE low for exactly 2 clocks, READY high again 5 clocks after accept.
- Plot x=400, y=0: CLIP pulses 1 cycle, WE stays 1 throughout, READY returns next cycle.
- Plot with GRANT=0 for 20 clocks, then 1: WE stays 1 in SETUP for 20 clocks, then the strobe completes. Dropping GRANT mid-strobe still yields full 2-clock WE low.
- SWAP_REQ, then FRAME_START: SEL_BUFF 0->1 and READY low until then. A following plot at (0,0) writes ADDR=0.
- Fill COLOR=0x00 into buffer 1: 120000 WE pulses, addresses 120000..239999 sequential. Toggling GRANT pauses without skipping addresses. SWAP_REQ mid-fill defers the swap to the first FRAME_START after the fill.
- Assert RST_N low mid-STROBE: WE=1, CE=1, DATA_OE=0 immediately (asynchronous), SEL_BUFF=0, READY=0 until the cycle after release.
